vga_timing: RTL and testbench

// - Free-running XGA 1024x768@60 raster timing generator (65 MHz pixel clock).
// - First stage of the video pipeline: its hcount/vcount/sync/blank outputs feed draw_background directly.
// - Every downstream draw stage registers and passes these signals through unchanged.

---
 rtl/vga_timing.sv | 115 +++++++++++
 tb/tb_vga_timing.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// vga_timing: free-running XGA 1024x768@60 raster timing generator (65 MHz pclk).
// Drives hcount/vcount plus sync and blank flags for the draw pipeline. All
// outputs are registered. The flags are decoded from the next-state counts, so
// each flag describes the same pixel as the counts registered with it.
// Optional feature macro: VGA_TIMING_FRAME_TICK_EN adds a one-pclk frame_tick
// pulse on the first cycle of vertical blank.
module vga_timing #(
  parameter int H_VIS  = 1024,
  parameter int H_FP   = 24,
  parameter int H_SYNC = 136,
  parameter int H_BP   = 160,
  parameter int V_VIS  = 768,
  parameter int V_FP   = 3,
  parameter int V_SYNC = 6,
  parameter int V_BP   = 29
) (
  input  logic        pclk,
  input  logic        rst_n,
  output logic [10:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic [10:0] vcount,
  output logic        vsync,
  output logic        vblnk
`ifdef VGA_TIMING_FRAME_TICK_EN
  ,
  output logic        frame_tick
`endif
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  // Decode boundaries in counter width so every compare is 11 bit on both sides.
  localparam logic [10:0] H_LAST     = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOT - 1);
  localparam logic [10:0] HBLNK_FROM = 11'(H_VIS);
  localparam logic [10:0] HSYNC_FROM = 11'(H_VIS + H_FP);
  localparam logic [10:0] HSYNC_TO   = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] VBLNK_FROM = 11'(V_VIS);
  localparam logic [10:0] VSYNC_FROM = 11'(V_VIS + V_FP);
  localparam logic [10:0] VSYNC_TO   = 11'(V_VIS + V_FP + V_SYNC);

  logic [10:0] hcount_nxt;
  logic [10:0] vcount_nxt;
  logic        hsync_nxt;
  logic        hblnk_nxt;
  logic        vsync_nxt;
  logic        vblnk_nxt;

  // Next raster position: step one pixel, wrap line end, wrap frame end.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    hcount_nxt = hcount + 11'd1;
    vcount_nxt = vcount;
    if (hcount == H_LAST) begin
      hcount_nxt = '0;
      if (vcount == V_LAST) begin
        vcount_nxt = '0;
      end else begin
        vcount_nxt = vcount + 11'd1;
      end
    end
  end

  // Flag decode on the next-state counts so the registered flags line up with
  // the registered counts.
  always_comb begin
    hblnk_nxt = (hcount_nxt >= HBLNK_FROM);
    hsync_nxt = (hcount_nxt >= HSYNC_FROM) && (hcount_nxt < HSYNC_TO);
    vblnk_nxt = (vcount_nxt >= VBLNK_FROM);
    vsync_nxt = (vcount_nxt >= VSYNC_FROM) && (vcount_nxt < VSYNC_TO);
  end

  // Counter and flag registers; reset parks the raster at visible pixel (0,0).
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
      hsync  <= 1'b0;
      hblnk  <= 1'b0;
      vsync  <= 1'b0;
      vblnk  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      hcount <= hcount_nxt;
      vcount <= vcount_nxt;
      hsync  <= hsync_nxt;
      hblnk  <= hblnk_nxt;
      vsync  <= vsync_nxt;
      vblnk  <= vblnk_nxt;
    end
  end

`ifdef VGA_TIMING_FRAME_TICK_EN
  logic frame_tick_nxt;

  // Frame pulse on the first pixel of vertical blank, decoded like the flags.
  always_comb begin
    frame_tick_nxt = (hcount_nxt == 11'd0) && (vcount_nxt == VBLNK_FROM);
  end

  // Registered frame pulse, aligned with the counts.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_tick_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks for vga_timing. A full-size XGA instance covers
// reset, horizontal decode and line wrap; a scaled-down instance (28 x 19 raster)
// covers vertical decode, frame wrap and frame_tick within a short run. Both
// share pclk and rst_n. Define VGA_TIMING_FRAME_TICK_EN to include frame_tick.
module tb_vga_timing;

  // Full-size geometry
  localparam int H_TOT = 1024 + 24 + 136 + 160;  // 1344
  localparam int V_TOT = 768 + 3 + 6 + 29;       // 806

  // Scaled-down geometry: H 16/2/4/6 -> 28, V 10/2/3/4 -> 19
  localparam int S_H_TOT   = 28;
  localparam int S_V_TOT   = 19;
  localparam int S_FRAME   = S_H_TOT * S_V_TOT;  // 532

  localparam int RUN = 3 * H_TOT + 10;           // 4042 cycles

  logic        pclk;
  logic        rst_n;

  logic [10:0] b_hc, b_vc, s_hc, s_vc;
  logic        b_hs, b_hb, b_vs, b_vb;
  logic        s_hs, s_hb, s_vs, s_vb;
  logic        b_ft, s_ft;

  int total = 0;
  int bad   = 0;

  vga_timing u_big (
    .pclk   (pclk),
    .rst_n  (rst_n),
    .hcount (b_hc),
    .hsync  (b_hs),
    .hblnk  (b_hb),
    .vcount (b_vc),
    .vsync  (b_vs),
    .vblnk  (b_vb)
`ifdef VGA_TIMING_FRAME_TICK_EN
    ,
    .frame_tick (b_ft)
`endif
  );

  vga_timing #(
    .H_VIS (16), .H_FP (2), .H_SYNC (4), .H_BP (6),
    .V_VIS (10), .V_FP (2), .V_SYNC (3), .V_BP (4)
  ) u_small (
    .pclk   (pclk),
    .rst_n  (rst_n),
    .hcount (s_hc),
    .hsync  (s_hs),
    .hblnk  (s_hb),
    .vcount (s_vc),
    .vsync  (s_vs),
    .vblnk  (s_vb)
`ifdef VGA_TIMING_FRAME_TICK_EN
    ,
    .frame_tick (s_ft)
`endif
  );

`ifndef VGA_TIMING_FRAME_TICK_EN
  assign b_ft = 1'b0;
  assign s_ft = 1'b0;
`endif

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Static width check: counters are 11 bit.
  initial begin
    if (H_TOT > 2048 || V_TOT > 2048) begin
      $display("FAIL width: H_TOT=%0d V_TOT=%0d exceed 2048", H_TOT, V_TOT);
      $fatal(1);
    end
  end

  // Watchdog: the run is a few thousand cycles.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string who);
    check({who, "_b_hcount"}, 32'(b_hc), 0);
    check({who, "_b_vcount"}, 32'(b_vc), 0);
    check({who, "_b_flags"},  32'({b_hs, b_hb, b_vs, b_vb, b_ft}), 0);
    check({who, "_s_hcount"}, 32'(s_hc), 0);
    check({who, "_s_vcount"}, 32'(s_vc), 0);
    check({who, "_s_flags"},  32'({s_hs, s_hb, s_vs, s_vb, s_ft}), 0);
  endtask

  // Statistics gathered during the free run
  int b_hb_cnt = 0, b_hs_cnt = 0, b_hs_first = -1, b_hs_last = -1;
  int b_wraps = 0, b_tick_cnt = 0;
  int b_prev_hc = 0, b_prev_vc = 0;
  int s_frame = 0, s_frame_start = 0;
  int s_vs_cnt = 0, s_vb_cnt = 0;
  int s_vs_first_h = -1, s_vs_first_v = -1, s_vs_last_h = -1, s_vs_last_v = -1;
  int s_rise_h = -1, s_rise_v = -1;
  int s_prev_hc = 0, s_prev_vc = 0;
  logic s_prev_vb = 1'b0;
  int s_tick_cnt = 0, s_last_tick = -1;
  int waited = 0;

  initial begin
    rst_n = 1'b0;
    repeat (10) @(posedge pclk);
    @(negedge pclk);
    check_all_zero("reset");

    rst_n = 1'b1;
    for (int i = 0; i < RUN; i++) begin
      @(negedge pclk);

      if (i < 3) begin
        check("b_hcount_start", 32'(b_hc), 32'(i + 1));
        check("b_vcount_start", 32'(b_vc), 0);
      end

      // Full-size: horizontal decode on line 0
      if (b_vc == 11'd0) begin
        if (b_hb) b_hb_cnt++;
        if (b_hs) begin
          b_hs_cnt++;
          if (b_hs_first < 0) b_hs_first = int'(b_hc);
          b_hs_last = int'(b_hc);
        end
      end
      if (b_prev_hc == H_TOT - 1) begin
        b_wraps++;
        if (b_prev_vc == 0) begin
          check("b_line_wrap_hc", 32'(b_hc), 0);
          check("b_line_wrap_vc", 32'(b_vc), 1);
          check("b_line_wrap_hblnk", 32'(b_hb), 0);
        end
      end
      if (b_ft) b_tick_cnt++;

      // Scaled-down: frame wrap and vertical decode
      if (s_hc == 11'd0 && s_vc == 11'd0) begin
        s_frame++;
        if (s_frame == 1) begin
          check("s_wrap_prev_hc", 32'(s_prev_hc), 32'(S_H_TOT - 1));
          check("s_wrap_prev_vc", 32'(s_prev_vc), 32'(S_V_TOT - 1));
          check("s_wrap_flags", 32'({s_hs, s_hb, s_vs, s_vb}), 0);
        end
        if (s_frame == 2) check("s_frame_len", 32'(i - s_frame_start), 32'(S_FRAME));
        s_frame_start = i;
      end
      if (s_frame == 1) begin
        if (s_vb) s_vb_cnt++;
        if (s_vs) begin
          s_vs_cnt++;
          if (s_vs_first_h < 0) begin
            s_vs_first_h = int'(s_hc);
            s_vs_first_v = int'(s_vc);
          end
          s_vs_last_h = int'(s_hc);
          s_vs_last_v = int'(s_vc);
        end
        if (s_vb && !s_prev_vb && s_rise_h < 0) begin
          s_rise_h = int'(s_hc);
          s_rise_v = int'(s_vc);
        end
      end
      if (s_ft && s_frame >= 1 && s_frame <= 3) begin
        s_tick_cnt++;
        check("s_tick_hc", 32'(s_hc), 0);
        check("s_tick_vc", 32'(s_vc), 10);
        if (s_last_tick >= 0) check("s_tick_spacing", 32'(i - s_last_tick), 32'(S_FRAME));
        s_last_tick = i;
      end

      b_prev_hc = int'(b_hc);
      b_prev_vc = int'(b_vc);
      s_prev_hc = int'(s_hc);
      s_prev_vc = int'(s_vc);
      s_prev_vb = s_vb;
    end

    // Full-size horizontal results
    check("b_hblnk_per_line", 32'(b_hb_cnt), 320);
    check("b_hsync_per_line", 32'(b_hs_cnt), 136);
    check("b_hsync_first", 32'(b_hs_first), 1048);
    check("b_hsync_last", 32'(b_hs_last), 1183);
    check("b_line_wraps", 32'(b_wraps), 3);
    check("b_no_tick_early", 32'(b_tick_cnt), 0);
    check("b_pos_hc", 32'(b_hc), 10);
    check("b_pos_vc", 32'(b_vc), 3);

    // Scaled-down vertical results
    check("s_vsync_cycles", 32'(s_vs_cnt), 3 * S_H_TOT);
    check("s_vblnk_cycles", 32'(s_vb_cnt), 9 * S_H_TOT);
    check("s_vsync_first_h", 32'(s_vs_first_h), 0);
    check("s_vsync_first_v", 32'(s_vs_first_v), 12);
    check("s_vsync_last_h", 32'(s_vs_last_h), 27);
    check("s_vsync_last_v", 32'(s_vs_last_v), 14);
    check("s_vblnk_rise_h", 32'(s_rise_h), 0);
    check("s_vblnk_rise_v", 32'(s_rise_v), 10);
`ifdef VGA_TIMING_FRAME_TICK_EN
    check("s_tick_count", 32'(s_tick_cnt), 3);
`endif

    // Async reset mid-line: reach hcount=500 on the full-size raster
    waited = 0;
    while (b_hc != 11'd500 && waited < 2000) begin
      @(negedge pclk);
      waited++;
    end
    check("b_reach_500", 32'(b_hc), 500);
    check("b_reach_500_vc", 32'(b_vc), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (3) @(negedge pclk);
    check_all_zero("reset_hold");

    rst_n = 1'b1;
    @(negedge pclk);
    check("restart_b_hc", 32'(b_hc), 1);
    check("restart_b_vc", 32'(b_vc), 0);
    check("restart_b_flags", 32'({b_hs, b_hb, b_vs, b_vb}), 0);
    check("restart_s_hc", 32'(s_hc), 1);
    check("restart_s_vc", 32'(s_vc), 0);
    check("restart_s_flags", 32'({s_hs, s_hb, s_vs, s_vb}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
